// File: rtl/sram_access_sequencer_pkg.sv
// Shared types and helpers for the SRAM access sequencer.
package sram_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    function automatic logic in_active(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] w, input logic [31:0] h);
        return (x < w) && (y < h);
    endfunction

endpackage

// File: rtl/sram_access_sequencer_if.sv
// Counter/coordinate inputs and SRAM/VGA control outputs of the sequencer.
interface sram_access_sequencer_if #(
    parameter int CNT_WIDTH = 10,
    parameter int COR_WIDTH = 10
);
    logic [CNT_WIDTH-1:0] i_count_n;
    logic [CNT_WIDTH-1:0] i_count_m;
    logic [COR_WIDTH-1:0] i_next_x_cor;
    logic [COR_WIDTH-1:0] i_next_y_cor;
    logic                 o_WE_n;
    logic                 o_OE_n;
    logic                 o_PRNG_en;
    logic                 o_addr_inc;
    logic                 o_wr_done;
    logic [1:0]           o_state;

    modport master (
        input  i_count_n, i_count_m, i_next_x_cor, i_next_y_cor,
        output o_WE_n, o_OE_n, o_PRNG_en, o_addr_inc, o_wr_done, o_state
    );

    modport slave (
        output i_count_n, i_count_m, i_next_x_cor, i_next_y_cor,
        input  o_WE_n, o_OE_n, o_PRNG_en, o_addr_inc, o_wr_done, o_state
    );
endinterface

// File: rtl/sram_access_sequencer_falling_edge_pulse.sv
// Turns an active-low key level into a single-cycle registered pulse on its falling edge.
// Latency: pulse is high the cycle after the first low sample; no backpressure.
module falling_edge_pulse (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_pulse
);
    logic dly;
    logic armed;

    // armed blocks the first post-reset sample so a key held through reset stays silent
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dly     <= 1'b1;
            armed   <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            dly     <= i_key;
            armed   <= 1'b1;
            o_pulse <= armed & dly & ~i_key;
        end
    end
endmodule

// File: rtl/sram_access_sequencer.sv
// SRAM write/read sequencer: key pulses drive an FSM owning WE_n/OE_n, frame bursts and PRNG requests.
// Latency: key low to WE_n/OE_n change is 2 cycles; no backpressure, counters are free-running inputs.
module sram_access_sequencer
    import sram_seq_pkg::*;
#(
    parameter int N         = 640,
    parameter int M         = 480,
    parameter int CNT_WIDTH = 10,
    parameter int COR_WIDTH = 10,
    parameter int PRNG_LEAD = 2,
    parameter int WR_FRAMES = 1,
    parameter int FRM_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_trigger,
    input  logic                  i_rd_trigger,
    sram_access_sequencer_if.master bus
);
    localparam logic [CNT_WIDTH-1:0] LAST_N = CNT_WIDTH'(N - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_M = CNT_WIDTH'(M - 1);
    localparam logic [CNT_WIDTH-1:0] PRNG_N = CNT_WIDTH'(N - PRNG_LEAD);
    localparam logic [FRM_WIDTH-1:0] LAST_F = FRM_WIDTH'(WR_FRAMES - 1);
    localparam logic [COR_WIDTH-1:0] ACT_W  = COR_WIDTH'(N);
    localparam logic [COR_WIDTH-1:0] ACT_H  = COR_WIDTH'(M);

    state_t               state;
    logic [FRM_WIDTH-1:0] frm;
    logic                 rsm;
    logic                 wr_p;
    logic                 rd_p;
    logic                 frame_end;
    logic                 last;
    logic                 rsm_nxt;

    falling_edge_pulse u_wr_edge (.i_clk(i_clk), .i_rst(i_rst), .i_key(i_wr_trigger), .o_pulse(wr_p));
    falling_edge_pulse u_rd_edge (.i_clk(i_clk), .i_rst(i_rst), .i_key(i_rd_trigger), .o_pulse(rd_p));

    assign frame_end = (bus.i_count_n == LAST_N) && (bus.i_count_m == LAST_M);
    assign last      = frame_end && (frm == LAST_F);
    // a read pulse coinciding with the final pixel still decides where the burst exits
    assign rsm_nxt   = rsm ^ rd_p;

    assign bus.o_addr_inc = in_active(32'(bus.i_next_x_cor), 32'(bus.i_next_y_cor),
                                      32'(ACT_W), 32'(ACT_H));
    assign bus.o_state    = state;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= S_IDLE;
            frm           <= '0;
            rsm           <= 1'b0;
            bus.o_WE_n    <= 1'b1;
            bus.o_OE_n    <= 1'b1;
            bus.o_PRNG_en <= 1'b0;
            bus.o_wr_done <= 1'b0;
        end else begin
            bus.o_wr_done <= 1'b0;
            bus.o_PRNG_en <= (state == S_WRITE) && (bus.i_count_n == PRNG_N);
            case (state)
                S_IDLE: begin
                    if (wr_p) begin
                        state      <= S_WRITE;
                        frm        <= '0;
                        rsm        <= 1'b0;
                        bus.o_WE_n <= 1'b0;
                        bus.o_OE_n <= 1'b1;
                    end else if (rd_p) begin
                        state      <= S_READ;
                        bus.o_OE_n <= 1'b0;
                    end
                end
                S_READ: begin
                    if (wr_p) begin
                        state      <= S_WRITE;
                        frm        <= '0;
                        rsm        <= 1'b1;
                        bus.o_WE_n <= 1'b0;
                        bus.o_OE_n <= 1'b1;
                    end else if (rd_p) begin
                        state      <= S_IDLE;
                        bus.o_OE_n <= 1'b1;
                    end
                end
                S_WRITE: begin
                    rsm <= rsm_nxt;
                    if (last) begin
                        bus.o_wr_done <= 1'b1;
                        bus.o_WE_n    <= 1'b1;
                        if (rsm_nxt) begin
                            state      <= S_READ;
                            bus.o_OE_n <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (frame_end) begin
                        frm <= frm + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    bus.o_WE_n <= 1'b1;
                    bus.o_OE_n <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with N=8, M=4, WR_FRAMES=2, PRNG_LEAD=2.
module tb_sram_access_sequencer;
    localparam int N = 8;
    localparam int M = 4;

    logic i_clk;
    logic i_rst;
    logic wr_trig, rd_trig;
    logic wr2, rd2;
    logic [9:0] cnt_n, cnt_m;
    int vectors = 0;
    int miscompares = 0;
    int prng_cnt = 0;
    int done_cnt = 0;
    int overlap = 0;

    sram_access_sequencer_if #(.CNT_WIDTH(10), .COR_WIDTH(10)) bus ();
    sram_access_sequencer_if #(.CNT_WIDTH(10), .COR_WIDTH(10)) bus2 ();

    sram_access_sequencer #(
        .N(N), .M(M), .CNT_WIDTH(10), .COR_WIDTH(10),
        .PRNG_LEAD(2), .WR_FRAMES(2), .FRM_WIDTH(4)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wr_trigger(wr_trig), .i_rd_trigger(rd_trig),
        .bus(bus)
    );

    sram_access_sequencer dut_default (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wr_trigger(wr2), .i_rd_trigger(rd2),
        .bus(bus2)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One clock step: the write counters advance only for cycles the DUT spent writing.
    task automatic tick();
        logic we_prev;
        we_prev = bus.o_WE_n;
        @(posedge i_clk);
        #1;
        if (we_prev == 1'b0) begin
            if (cnt_n == 10'(N - 1)) begin
                cnt_n = '0;
                cnt_m = (cnt_m == 10'(M - 1)) ? 10'd0 : cnt_m + 10'd1;
            end else begin
                cnt_n = cnt_n + 10'd1;
            end
        end else begin
            cnt_n = '0;
            cnt_m = '0;
        end
        bus.i_count_n = cnt_n;
        bus.i_count_m = cnt_m;
        if (bus.o_PRNG_en === 1'b1) prng_cnt++;
        if (bus.o_wr_done === 1'b1) done_cnt++;
        if (bus.o_WE_n === 1'b0 && bus.o_OE_n === 1'b0) overlap++;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (2) tick();
        vectors++; if (bus.o_WE_n !== 1'b1) begin miscompares++; $display("FAIL reset_we got %b want 1", bus.o_WE_n); end
        vectors++; if (bus.o_OE_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe got %b want 1", bus.o_OE_n); end
        vectors++; if (bus.o_PRNG_en !== 1'b0) begin miscompares++; $display("FAIL reset_prng got %b want 0", bus.o_PRNG_en); end
        vectors++; if (bus.o_wr_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.o_wr_done); end
        vectors++; if (bus.o_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", bus.o_state); end
        i_rst = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single_write();
        int rise_t, done_t, first_prng, low_cycles, p0, d0;
        logic we_before, we_at1, we_at2;
        rise_t = -1; done_t = -1; first_prng = -1; low_cycles = 0;
        we_at1 = 1'bx; we_at2 = 1'bx;
        p0 = prng_cnt; d0 = done_cnt;
        wr_trig = 1'b0;
        for (int t = 1; t <= 90; t++) begin
            we_before = bus.o_WE_n;
            tick();
            if (t == 20) wr_trig = 1'b1;
            if (t == 1) we_at1 = bus.o_WE_n;
            if (t == 2) we_at2 = bus.o_WE_n;
            if (bus.o_WE_n === 1'b0) low_cycles++;
            if (we_before === 1'b0 && bus.o_WE_n === 1'b1 && rise_t < 0) rise_t = t;
            if (bus.o_wr_done === 1'b1 && done_t < 0) done_t = t;
            if (bus.o_PRNG_en === 1'b1 && first_prng < 0) first_prng = t;
        end
        vectors++; if (we_at1 !== 1'b1) begin miscompares++; $display("FAIL wr_latency_1 got %b want 1", we_at1); end
        vectors++; if (we_at2 !== 1'b0) begin miscompares++; $display("FAIL wr_latency_2 got %b want 0", we_at2); end
        vectors++; if (low_cycles != 64) begin miscompares++; $display("FAIL burst_length got %0d want 64", low_cycles); end
        vectors++; if (rise_t != 66) begin miscompares++; $display("FAIL burst_end_cycle got %0d want 66", rise_t); end
        vectors++; if (done_t != 66) begin miscompares++; $display("FAIL done_cycle got %0d want 66", done_t); end
        vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL done_count got %0d want 1", done_cnt - d0); end
        vectors++; if (first_prng != 9) begin miscompares++; $display("FAIL prng_first got %0d want 9", first_prng); end
        vectors++; if (prng_cnt - p0 != 8) begin miscompares++; $display("FAIL prng_count got %0d want 8", prng_cnt - p0); end
        vectors++; if (bus.o_state !== 2'd0) begin miscompares++; $display("FAIL write_exit_state got %0d want 0", bus.o_state); end
    endtask

    task automatic test_preempt_resume();
        int p0;
        logic we_before, found, oe_rise, done_rise;
        logic [1:0] st_rise;
        found = 1'b0; oe_rise = 1'bx; done_rise = 1'bx; st_rise = 2'bxx;
        rd_trig = 1'b0; tick(); rd_trig = 1'b1; tick();
        vectors++; if (bus.o_state !== 2'd2) begin miscompares++; $display("FAIL read_state got %0d want 2", bus.o_state); end
        vectors++; if (bus.o_OE_n !== 1'b0) begin miscompares++; $display("FAIL read_oe got %b want 0", bus.o_OE_n); end
        p0 = prng_cnt;
        repeat (5) tick();
        vectors++; if (prng_cnt != p0) begin miscompares++; $display("FAIL prng_in_read got %0d want %0d", prng_cnt, p0); end
        wr_trig = 1'b0; tick(); wr_trig = 1'b1; tick();
        vectors++; if (bus.o_OE_n !== 1'b1) begin miscompares++; $display("FAIL preempt_oe got %b want 1", bus.o_OE_n); end
        vectors++; if (bus.o_WE_n !== 1'b0) begin miscompares++; $display("FAIL preempt_we got %b want 0", bus.o_WE_n); end
        for (int t = 0; t < 100 && !found; t++) begin
            we_before = bus.o_WE_n;
            tick();
            if (we_before === 1'b0 && bus.o_WE_n === 1'b1) begin
                found = 1'b1; oe_rise = bus.o_OE_n; done_rise = bus.o_wr_done; st_rise = bus.o_state;
            end
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL resume_timeout got %b want 1", found); end
        vectors++; if (oe_rise !== 1'b0) begin miscompares++; $display("FAIL resume_oe got %b want 0", oe_rise); end
        vectors++; if (done_rise !== 1'b1) begin miscompares++; $display("FAIL resume_done got %b want 1", done_rise); end
        vectors++; if (st_rise !== 2'd2) begin miscompares++; $display("FAIL resume_state got %0d want 2", st_rise); end
    endtask

    task automatic test_cancel_and_simultaneous();
        logic we_before, found;
        logic [1:0] st_end;
        wr_trig = 1'b0; tick(); wr_trig = 1'b1; tick();
        vectors++; if (bus.o_state !== 2'd1) begin miscompares++; $display("FAIL cancel_enter got %0d want 1", bus.o_state); end
        repeat (10) tick();
        rd_trig = 1'b0; tick(); rd_trig = 1'b1;
        found = 1'b0; st_end = 2'bxx;
        for (int t = 0; t < 100 && !found; t++) begin
            we_before = bus.o_WE_n;
            tick();
            if (we_before === 1'b0 && bus.o_WE_n === 1'b1) begin found = 1'b1; st_end = bus.o_state; end
        end
        vectors++; if (st_end !== 2'd0 || found !== 1'b1) begin miscompares++; $display("FAIL cancel_resume got state %0d found %b want 0 1", st_end, found); end
        vectors++; if (bus.o_OE_n !== 1'b1) begin miscompares++; $display("FAIL cancel_oe got %b want 1", bus.o_OE_n); end
        repeat (2) tick();
        wr_trig = 1'b0; rd_trig = 1'b0; tick(); tick();
        vectors++; if (bus.o_state !== 2'd1) begin miscompares++; $display("FAIL simul_state got %0d want 1", bus.o_state); end
        vectors++; if (bus.o_OE_n !== 1'b1) begin miscompares++; $display("FAIL simul_oe got %b want 1", bus.o_OE_n); end
        repeat (3) tick();
        wr_trig = 1'b1; rd_trig = 1'b1;
        found = 1'b0; st_end = 2'bxx;
        for (int t = 0; t < 100 && !found; t++) begin
            we_before = bus.o_WE_n;
            tick();
            if (we_before === 1'b0 && bus.o_WE_n === 1'b1) begin found = 1'b1; st_end = bus.o_state; end
        end
        vectors++; if (st_end !== 2'd0 || found !== 1'b1) begin miscompares++; $display("FAIL simul_exit got state %0d found %b want 0 1", st_end, found); end
        vectors++; if (overlap != 0) begin miscompares++; $display("FAIL we_oe_overlap got %0d want 0", overlap); end
    endtask

    task automatic test_active_region();
        bus.i_next_x_cor = 10'd7; bus.i_next_y_cor = 10'd3; #1;
        vectors++; if (bus.o_addr_inc !== 1'b1) begin miscompares++; $display("FAIL active_7_3 got %b want 1", bus.o_addr_inc); end
        bus.i_next_x_cor = 10'd8; bus.i_next_y_cor = 10'd3; #1;
        vectors++; if (bus.o_addr_inc !== 1'b0) begin miscompares++; $display("FAIL active_8_3 got %b want 0", bus.o_addr_inc); end
        bus.i_next_x_cor = 10'd7; bus.i_next_y_cor = 10'd4; #1;
        vectors++; if (bus.o_addr_inc !== 1'b0) begin miscompares++; $display("FAIL active_7_4 got %b want 0", bus.o_addr_inc); end
        bus.i_next_x_cor = 10'd0; bus.i_next_y_cor = 10'd0; #1;
        vectors++; if (bus.o_addr_inc !== 1'b1) begin miscompares++; $display("FAIL active_0_0 got %b want 1", bus.o_addr_inc); end
        bus2.i_next_x_cor = 10'd639; bus2.i_next_y_cor = 10'd479; #1;
        vectors++; if (bus2.o_addr_inc !== 1'b1) begin miscompares++; $display("FAIL active_639_479 got %b want 1", bus2.o_addr_inc); end
        bus2.i_next_x_cor = 10'd640; bus2.i_next_y_cor = 10'd0; #1;
        vectors++; if (bus2.o_addr_inc !== 1'b0) begin miscompares++; $display("FAIL active_640_0 got %b want 0", bus2.o_addr_inc); end
    endtask

    task automatic test_reset_mid_burst();
        int low_cycles, d0;
        logic found;
        wr_trig = 1'b0; tick(); wr_trig = 1'b1; tick();
        repeat (50) tick();
        vectors++; if (cnt_m !== 10'd2 || bus.o_WE_n !== 1'b0) begin miscompares++; $display("FAIL midburst_pos got row %0d we %b want 2 0", cnt_m, bus.o_WE_n); end
        wr_trig = 1'b0;
        #2 i_rst = 1'b0;
        #1;
        vectors++; if (bus.o_WE_n !== 1'b1) begin miscompares++; $display("FAIL async_we got %b want 1", bus.o_WE_n); end
        vectors++; if (bus.o_OE_n !== 1'b1) begin miscompares++; $display("FAIL async_oe got %b want 1", bus.o_OE_n); end
        vectors++; if (bus.o_PRNG_en !== 1'b0) begin miscompares++; $display("FAIL async_prng got %b want 0", bus.o_PRNG_en); end
        vectors++; if (bus.o_wr_done !== 1'b0) begin miscompares++; $display("FAIL async_done got %b want 0", bus.o_wr_done); end
        vectors++; if (bus.o_state !== 2'd0) begin miscompares++; $display("FAIL async_state got %0d want 0", bus.o_state); end
        repeat (3) tick();
        i_rst = 1'b1;
        low_cycles = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.o_WE_n !== 1'b1) low_cycles++;
        end
        vectors++; if (low_cycles != 0) begin miscompares++; $display("FAIL held_key_after_reset got %0d write cycles want 0", low_cycles); end
        wr_trig = 1'b1; tick();
        wr_trig = 1'b0; tick(); tick();
        vectors++; if (bus.o_WE_n !== 1'b0) begin miscompares++; $display("FAIL retrigger_we got %b want 0", bus.o_WE_n); end
        wr_trig = 1'b1;
        d0 = done_cnt; found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            tick();
            if (done_cnt != d0) found = 1'b1;
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL retrigger_done got %b want 1", found); end
    endtask

    initial begin
        i_rst = 1'b0;
        wr_trig = 1'b1; rd_trig = 1'b1;
        wr2 = 1'b1; rd2 = 1'b1;
        cnt_n = '0; cnt_m = '0;
        bus.i_count_n = '0; bus.i_count_m = '0;
        bus.i_next_x_cor = '0; bus.i_next_y_cor = '0;
        bus2.i_count_n = '0; bus2.i_count_m = '0;
        bus2.i_next_x_cor = '0; bus2.i_next_y_cor = '0;
        test_reset();
        test_single_write();
        test_preempt_resume();
        test_cancel_and_simultaneous();
        test_active_region();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_access_sequencer.md
# sram_access_sequencer

Parametrised SRAM access sequencer: the successor to the single-mode write/read control generator between the key/trigger inputs, the pixel PRNG, the SRAM chip and the VGA address path. It turns debounced active-low key triggers into single-cycle pulses and runs a state machine that owns the SRAM write enable (`o_WE_n`) and output enable (`o_OE_n`). New behaviour:
- multi-frame write bursts;
- write preemption of an active read, with automatic read resumption;
- PRNG enable gated by state and with a parameterised lead;
- active-region bounds taken from parameters.

## Interface
- `N`, 640: pixels per row (write horizontal extent and active width).
- `M`, 480: rows per frame (write vertical extent and active height).
- `CNT_WIDTH`, 10: width of `i_count_n`/`i_count_m`; requires 2^CNT_WIDTH ≥ max(N,M).
- `COR_WIDTH`, 10: width of VGA next-pixel coordinates.
- `PRNG_LEAD`, 2: cycles before row end at which `o_PRNG_en` fires; legal 1..N-1.
- `WR_FRAMES`, 1: frames written per write trigger; legal ≥1.
- `FRM_WIDTH`, 4: frame counter width; requires 2^FRM_WIDTH ≥ WR_FRAMES.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_wr_trigger` in 1: active-low write key (level).
- `i_rd_trigger` in 1: active-low read-toggle key (level).
- `i_count_n` in CNT_WIDTH: write column counter, 0..N-1.
- `i_count_m` in CNT_WIDTH: write row counter, 0..M-1.
- `i_next_x_cor` in COR_WIDTH: VGA next-pixel x.
- `i_next_y_cor` in COR_WIDTH: VGA next-pixel y.
- `o_WE_n` out 1: SRAM write enable, active low.
- `o_OE_n` out 1: SRAM output enable, active low.
- `o_PRNG_en` out 1: one-cycle request for a new row of N pixels.
- `o_addr_inc` out 1: VGA next pixel lies in the active region.
- `o_wr_done` out 1: one-cycle pulse when a write burst completes.
- `o_state` out 2: current FSM state.

## Operation
- **Edge detect, per trigger:**
  - `dly` register; reset value 1.
  - Internal pulse `p` is registered high for one cycle after the edge where the trigger is 0 and `dly` is 1.
  - Holding a key low produces exactly one pulse.
- **States:** `S_IDLE`=0, `S_WRITE`=1, `S_READ`=2.
- **Resume flag `rsm`:** reset value 0.
- **Write-burst end condition `last`:** `i_count_n`==N-1 && `i_count_m`==M-1 && `frm`==WR_FRAMES-1.
- **`S_IDLE`:**
  - `wr_p` → `S_WRITE`, with `frm`=0 and `rsm`=0.
  - Else `rd_p` → `S_READ`.
  - Simultaneous pulses: write wins and the read pulse is dropped.
- **`S_READ`:**
  - `wr_p` → `S_WRITE`, with `frm`=0 and `rsm`=1 (write preempts read).
  - Else `rd_p` → `S_IDLE`.
  - Simultaneous pulses: write wins, `rsm`=1.
- **`S_WRITE`:**
  - At (N-1,M-1), `frm` increments.
  - On `last`: → `S_READ` if `rsm`, else `S_IDLE`; `o_wr_done` is pulsed on the same edge.
  - `rd_p` toggles `rsm`. If `rd_p` coincides with `last`, the toggled value decides the exit state.
  - `wr_p` is ignored; `frm` is not restarted.
- **Registered outputs:** `o_WE_n` = (state≠`S_WRITE`), `o_OE_n` = (state≠`S_READ`). They are never both low.
- **`o_PRNG_en`:** registered. High for one cycle after the edge where state is `S_WRITE` && `i_count_n`==N-PRNG_LEAD. Fires every row of the burst, including the row containing the `last` condition.
- **`o_addr_inc`:** combinational, `i_next_x_cor`<N && `i_next_y_cor`<M. Comparison constants are sized to COR_WIDTH.
- **Reset values:**
  - `o_WE_n`=1, `o_OE_n`=1, `o_PRNG_en`=0, `o_wr_done`=0.
  - State `S_IDLE`, `frm`=0, `rsm`=0, `dly`=1, pulses 0.
- **Reset mid-burst:** immediate abort to reset values. The burst does not resume after reset release.

## Timing
- **Write trigger:** key low sampled at edge k → `wr_p` high after k → `o_WE_n` low after k+1 (2-cycle latency). The same applies to `o_OE_n` via `rd_p`.
- **Burst end:** `o_WE_n` rises on the edge that samples `last`.
  - With `rsm`=1, `o_OE_n` falls on that same edge (1-cycle handover, no overlap).
  - `o_wr_done` is high for that one cycle.
- **Preemption:** `o_OE_n` rises on the same edge that `o_WE_n` falls.
- **`o_PRNG_en`:** asserts one cycle after `i_count_n`==N-PRNG_LEAD is sampled.

## Structure
- **Package `sram_seq_pkg`:** `state_t` enum (`S_IDLE`, `S_WRITE`, `S_READ`; 2 bits), plus `function in_active(x,y,w,h)`.
- **Sub-module `falling_edge_pulse`:** one clock, async active-low reset, `dly` resets to 1. Instantiated twice, once per trigger.
- The FSM, frame counter, resume flag and output registers live in the top module.

## Test plan
Bench parameters unless stated: N=8, M=4, WR_FRAMES=2, PRNG_LEAD=2.
- **Single write:** hold `i_wr_trigger` low for 20 cycles in `S_IDLE` → `o_WE_n` low 2 cycles after the first low sample; exactly one burst; `o_WE_n` high after the second (7,3); `o_wr_done` pulses once; state returns to `S_IDLE`.
- **PRNG cadence:** during a burst → `o_PRNG_en` high one cycle after each `i_count_n`==6; 8 pulses per 2-frame burst; none in `S_IDLE`/`S_READ`.
- **Preempt and resume:**
  - `rd` pulse → `S_READ`, `o_OE_n`=0.
  - `wr` pulse → `o_OE_n`=1 and `o_WE_n`=0 on the same edge.
  - After the burst → `o_OE_n`=0 on the edge `o_WE_n` rises.
  - `o_WE_n`/`o_OE_n` never both 0.
- **Cancel resume and simultaneous pulses:**
  - `rd` pulse mid-burst after preemption → ends in `S_IDLE`.
  - `wr` and `rd` falling in the same cycle from `S_IDLE` → `S_WRITE`, `rsm`=0.
- **Active region:** (7,3) → `o_addr_inc`=1; (8,3) → 0; (7,4) → 0; (0,0) → 1; with defaults (639,479) → 1, (640,0) → 0.
- **Reset mid-burst:** assert `i_rst`=0 at frame 1, row 2 → all outputs take their reset values asynchronously; after release no write occurs until a new trigger edge; a key held low through reset release produces no pulse.
